fifo_ctrl_16: RTL and testbench

FIFO_CTRL_16 -- requirements
Module: fifo_ctrl_16

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_mem_16.sv | 31 +++
 rtl/fifo_ctrl_16.sv | 104 ++++++++++
 tb/tb_fifo_ctrl_16.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared state codes, depth and pointer/count widths for    |
// |            the 16-entry FIFO controller and its status decoder.      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package fifo_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int PTR_W      = 4;
    localparam int CNT_W      = 5;
    localparam int STATE_W    = 3;

    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [2:0] ST_INIT   = 3'b000;
    localparam logic [2:0] ST_NO_OP  = 3'b001;
    localparam logic [2:0] ST_WRITE  = 3'b010;
    localparam logic [2:0] ST_WR_ERR = 3'b011;
    localparam logic [2:0] ST_READ   = 3'b100;
    localparam logic [2:0] ST_RD_ERR = 3'b101;

endpackage
`default_nettype wire

// File: rtl/fifo_mem_16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem_16 : 16 x DATA_W register file, one synchronous write port, |
// |               one asynchronous read port, no reset.                  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module fifo_mem_16
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  ptr_t              i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  ptr_t              i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fifo_ctrl_16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_ctrl_16 : 16-entry synchronous FIFO controller with registered  |
// |                read data, operation code and occupancy.              |
// | Option       : FIFO_DOUT_CLR_EN - clear d_out on non-read cycles.    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module fifo_ctrl_16
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    output logic [2:0]        state,
    output logic [4:0]        data_count
);

    ptr_t              r_head;
    ptr_t              r_tail;
    cnt_t              r_count;
    state_t            r_state;
    logic [DATA_W-1:0] r_dout;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_ok;
    logic              w_rd_ok;
    state_t            w_next;
    logic [DATA_W-1:0] w_rd_data;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Simultaneous requests cancel each other and fall through to NO_OP.
    always_comb begin
        w_next  = ST_NO_OP;
        w_wr_ok = 1'b0;
        w_rd_ok = 1'b0;
        if (wr_en && !rd_en) begin
            if (w_full) begin
                w_next = ST_WR_ERR;
            end else begin
                w_next  = ST_WRITE;
                w_wr_ok = 1'b1;
            end
        end else if (rd_en && !wr_en) begin
            if (w_empty) begin
                w_next = ST_RD_ERR;
            end else begin
                w_next  = ST_READ;
                w_rd_ok = 1'b1;
            end
        end
    end

    fifo_mem_16 #(
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_tail),
        .i_wdata (d_in),
        .i_raddr (r_head),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next;
            if (w_wr_ok) begin
                r_tail  <= r_tail + 4'd1;
                r_count <= r_count + 5'd1;
            end
            if (w_rd_ok) begin
                r_head  <= r_head + 4'd1;
                r_count <= r_count - 5'd1;
                r_dout  <= w_rd_data;
            end
`ifdef FIFO_DOUT_CLR_EN
            else begin
                r_dout <= '0;
            end
`endif
        end
    end

    assign d_out      = r_dout;
    assign state      = r_state;
    assign data_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl_16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_ctrl_16 : scoreboard bench for fifo_ctrl_16.                 |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_fifo_ctrl_16;

    localparam logic [2:0] E_INIT   = 3'b000;
    localparam logic [2:0] E_NO_OP  = 3'b001;
    localparam logic [2:0] E_WRITE  = 3'b010;
    localparam logic [2:0] E_WR_ERR = 3'b011;
    localparam logic [2:0] E_READ   = 3'b100;
    localparam logic [2:0] E_RD_ERR = 3'b101;

    logic        clk;
    logic        reset_n;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic [2:0]  state;
    logic [4:0]  data_count;

    int          n_chk;
    int          n_pass;
    logic [31:0] sb_q [$];
    int          m_count;
    logic [31:0] m_dout;

    fifo_ctrl_16 #(
        .DATA_W (32),
        .DEPTH  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .d_in       (d_in),
        .d_out      (d_out),
        .state      (state),
        .data_count (data_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model predicts, the DUT is checked after the edge.
    task automatic step(input logic wr, input logic rd, input logic [31:0] din);
        logic [2:0] e_state;
        @(negedge clk);
        wr_en = wr;
        rd_en = rd;
        d_in  = din;
        e_state = E_NO_OP;
        if (wr && !rd) begin
            if (m_count < 16) begin
                e_state = E_WRITE;
                sb_q.push_back(din);
                m_count++;
            end else begin
                e_state = E_WR_ERR;
            end
        end else if (rd && !wr) begin
            if (m_count > 0) begin
                e_state = E_READ;
                m_dout  = sb_q.pop_front();
                m_count--;
            end else begin
                e_state = E_RD_ERR;
            end
        end
`ifdef FIFO_DOUT_CLR_EN
        if (e_state != E_READ) m_dout = 32'h0;
`endif
        @(posedge clk);
        #1;
        chk("state", {29'h0, state}, {29'h0, e_state});
        chk("count", {27'h0, data_count}, 32'(m_count));
        chk("d_out", d_out, m_dout);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_count = 0;
        m_dout  = 32'h0;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        d_in    = 32'h0;
        reset_n = 1'b0;
        model_reset();

        #12;
        chk("rst_state", {29'h0, state}, {29'h0, E_INIT});
        chk("rst_count", {27'h0, data_count}, 32'h0);
        chk("rst_dout", d_out, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fill, overflow, drain, underflow.
        for (int i = 1; i <= 17; i++) step(1'b1, 1'b0, 32'(i));
        for (int i = 1; i <= 17; i++) step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Pointer wrap.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h100 + 32'(i));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'hA0 + 32'(i));
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'h0);

        // Cancelling requests at count 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h200 + 32'(i));
        step(1'b0, 1'b1, 32'h0);
        step(1'b1, 1'b0, 32'h300);
        step(1'b1, 1'b1, 32'hDEAD);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h0);

        // Idle after reading 0x55.
        step(1'b1, 1'b0, 32'h55);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Asynchronous reset mid-write at count 7.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'h400 + 32'(i));
        @(negedge clk);
        wr_en = 1'b1;
        d_in  = 32'h999;
        #2;
        reset_n = 1'b0;
        wr_en   = 1'b0;
        #1;
        chk("arst_state", {29'h0, state}, {29'h0, E_INIT});
        chk("arst_count", {27'h0, data_count}, 32'h0);
        chk("arst_dout", d_out, 32'h0);
        #1;
        reset_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 32'h77);
        step(1'b1, 1'b0, 32'h78);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h0);

        // Random mix.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
